// File: rtl/knn_dist_if.sv
// Training-point stream for knn_dist: valid/ready handshake
// carrying one labelled coordinate pair per transfer.
interface knn_dist_if #(
  parameter int COORD_W    = 16,
  parameter int LABEL_BITS = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [COORD_W-1:0]    train_x;
  logic signed [COORD_W-1:0]    train_y;
  logic        [LABEL_BITS-1:0] train_label;

  modport master (
    output in_valid,
    output train_x,
    output train_y,
    output train_label,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  train_x,
    input  train_y,
    input  train_label,
    output in_ready
  );
endinterface

// File: rtl/knn_dist.sv
// Squared-distance engine for k-NN: 2-stage pipeline over NBR_POINTS points.
// Define KNN_DIST_SAT_EN to clamp dist_entry instead of wrapping.
module knn_dist #(
  parameter int DATA_W     = 32,
  parameter int COORD_W    = 16,
  parameter int LABEL_BITS = 8,
  parameter int NBR_POINTS = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic signed [COORD_W-1:0]         test_x,
  input  logic signed [COORD_W-1:0]         test_y,
  knn_dist_if.slave                         trn,
  output logic        [DATA_W-1:0]          dist_entry,
  output logic        [LABEL_BITS-1:0]      label_entry,
  output logic                              en_list,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(NBR_POINTS+1)-1:0]   count
);

  localparam int CNT_W = $clog2(NBR_POINTS + 1);
  localparam int DIF_W = COORD_W + 1;
  localparam int FW    = 2 * DIF_W;
  localparam int WW    = (FW > DATA_W) ? FW : DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic                    vld;
    logic signed [COORD_W:0] dx;
    logic signed [COORD_W:0] dy;
    logic [LABEL_BITS-1:0]   label;
  } s1_t;

  state_t state;
  state_t state_nx;
  s1_t    s1;

  logic signed [COORD_W-1:0] tx;
  logic signed [COORD_W-1:0] ty;
  logic signed [COORD_W:0]   dx_c;
  logic signed [COORD_W:0]   dy_c;
  logic signed [FW-1:0]      sq_x;
  logic signed [FW-1:0]      sq_y;
  logic        [FW-1:0]      sum_full;
  logic        [WW-1:0]      sum_w;
  logic        [DATA_W-1:0]  dist_c;
  logic                      start_ok;
  logic                      xfer;
  logic                      last_in;

  assign start_ok = start && (state != RUN);
  assign last_in  = (count == CNT_W'(NBR_POINTS));
  assign trn.in_ready = (state == RUN) && !last_in;
  assign xfer     = trn.in_valid && trn.in_ready;
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      start_ok:                          state_nx = RUN;
      busy && last_in && !s1.vld:        state_nx = DONE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx    <= '0;
      ty    <= '0;
      count <= '0;
    end else if (start_ok) begin
      tx    <= test_x;
      ty    <= test_y;
      count <= '0;
    end else if (xfer) begin
      count <= count + CNT_W'(1);
    end
  end

  assign dx_c = {trn.train_x[COORD_W-1], trn.train_x}
              - {tx[COORD_W-1], tx};
  assign dy_c = {trn.train_y[COORD_W-1], trn.train_y}
              - {ty[COORD_W-1], ty};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
    end else begin
      s1.vld <= xfer;
      if (xfer) begin
        s1.dx    <= dx_c;
        s1.dy    <= dy_c;
        s1.label <= trn.train_label;
      end
    end
  end

  // Squares are non-negative and their sum fits FW bits unsigned.
  assign sq_x     = s1.dx * s1.dx;
  assign sq_y     = s1.dy * s1.dy;
  assign sum_full = $unsigned(sq_x) + $unsigned(sq_y);
  assign sum_w    = WW'(sum_full);

`ifdef KNN_DIST_SAT_EN
  assign dist_c = (sum_w > WW'({DATA_W{1'b1}}))
                ? '1 : sum_w[DATA_W-1:0];
`else
  logic unused_hi;
  assign unused_hi = ^sum_w;
  assign dist_c    = sum_w[DATA_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_list     <= 1'b0;
      dist_entry  <= '0;
      label_entry <= '0;
    end else begin
      en_list <= s1.vld;
      if (s1.vld) begin
        dist_entry  <= dist_c;
        label_entry <= s1.label;
      end
    end
  end

endmodule

// File: tb/tb_knn_dist.sv
// Directed bench for knn_dist (NBR_POINTS=4); a negedge monitor
// scores every en_list strobe against hand-computed distances.
module tb_knn_dist;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int LB = 8;
  localparam int NP = 4;
  localparam int NW = $clog2(NP + 1);

`ifdef KNN_DIST_SAT_EN
  localparam logic [DW-1:0] EXP_OVF = 32'd4294967295;
`else
  localparam logic [DW-1:0] EXP_OVF = 32'd4294705154;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic signed [CW-1:0] test_x = '0;
  logic signed [CW-1:0] test_y = '0;
  logic [DW-1:0]        dist_entry;
  logic [LB-1:0]        label_entry;
  logic                 en_list;
  logic                 busy;
  logic                 done;
  logic [NW-1:0]        count;

  knn_dist_if #(.COORD_W(CW), .LABEL_BITS(LB)) trn ();

  knn_dist #(
    .DATA_W(DW), .COORD_W(CW),
    .LABEL_BITS(LB), .NBR_POINTS(NP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .test_x      (test_x),
    .test_y      (test_y),
    .trn         (trn),
    .dist_entry  (dist_entry),
    .label_entry (label_entry),
    .en_list     (en_list),
    .busy        (busy),
    .done        (done),
    .count       (count)
  );

  always #5 clk = ~clk;

  int n_cmp    = 0;
  int n_bad    = 0;
  int n_strobe = 0;
  int s0       = 0;
  logic [DW+LB-1:0] exp_q[$];
  logic [DW+LB-1:0] e_mon;
  logic [DW+LB-1:0] e_drop;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && en_list) begin
      n_strobe++;
      if (exp_q.size() == 0) begin
        chk("stray_strobe", 64'd1, 64'd0);
      end else begin
        e_mon = exp_q.pop_front();
        chk("strobe_dist", dist_entry, e_mon[DW+LB-1:LB]);
        chk("strobe_label", label_entry, e_mon[LB-1:0]);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic signed [CW-1:0] x,
                          input logic signed [CW-1:0] y);
    start  = 1'b1;
    test_x = x;
    test_y = y;
    tick();
    start  = 1'b0;
  endtask

  task automatic push(input logic signed [CW-1:0] x,
                      input logic signed [CW-1:0] y,
                      input logic [LB-1:0] l,
                      input logic [DW-1:0] d,
                      input bit keep);
    int n = 0;
    trn.train_x     = x;
    trn.train_y     = y;
    trn.train_label = l;
    trn.in_valid    = 1'b1;
    while (!trn.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) begin
      chk("ready_timeout", 64'd0, 64'd1);
    end else begin
      exp_q.push_back({d, l});
      tick();
    end
    if (!keep) trn.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    trn.in_valid    = 1'b0;
    trn.train_x     = '0;
    trn.train_y     = '0;
    trn.train_label = '0;
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", trn.in_ready, 0);
    chk("rst_en", en_list, 0);
    chk("rst_dist", dist_entry, 0);
    chk("rst_label", label_entry, 0);
    chk("rst_count", count, 0);
    rst = 1'b1;
    tick(3);
    chk("idle_busy", busy, 0);
    chk("idle_ready", trn.in_ready, 0);
    chk("idle_en", en_list, 0);

    // run A: latency, gaps, start ignored mid-run
    do_start(3, 4);
    chk("a_busy", busy, 1);
    chk("a_count0", count, 0);
    s0 = n_strobe;
    push(0, 0, 5, 25, 0);
    chk("a_lat1_en", en_list, 0);
    chk("a_count1", count, 1);
    tick();
    chk("a_lat2_en", en_list, 1);
    chk("a_dist", dist_entry, 25);
    chk("a_label", label_entry, 5);
    tick();
    push(3, 4, 1, 0, 0);
    tick(3);
    chk("a_two_strobes", n_strobe - s0, 2);
    chk("a_count2", count, 2);
    chk("a_hold_en", en_list, 0);
    chk("a_hold_dist", dist_entry, 0);
    chk("a_hold_label", label_entry, 1);
    start  = 1'b1;
    test_x = 100;
    test_y = 100;
    tick();
    start  = 1'b0;
    chk("a_ign_count", count, 2);
    chk("a_ign_busy", busy, 1);
    push(6, 8, 2, 25, 0);
    push(4, 4, 3, 1, 0);
    chk("a_full_ready", trn.in_ready, 0);
    chk("a_full_count", count, 4);
    wait_done();
    chk("a_done_busy", busy, 0);

    // run B: streaming from DONE
    do_start(0, 0);
    chk("b_count0", count, 0);
    chk("b_busy", busy, 1);
    chk("b_done0", done, 0);
    s0 = n_strobe;
    push(1, 1, 1, 2, 1);
    push(2, 2, 2, 8, 1);
    push(3, 4, 3, 25, 1);
    push(6, 8, 4, 100, 1);
    trn.in_valid = 1'b0;
    chk("b_ready_off", trn.in_ready, 0);
    chk("b_count4", count, 4);
    chk("b_s3_en", en_list, 1);
    chk("b_s3_dist", dist_entry, 25);
    tick();
    chk("b_s4_en", en_list, 1);
    chk("b_s4_dist", dist_entry, 100);
    chk("b_s4_label", label_entry, 4);
    chk("b_s4_done", done, 0);
    tick();
    chk("b_post_en", en_list, 0);
    chk("b_done", done, 1);
    chk("b_busy_off", busy, 0);
    chk("b_strobes", n_strobe - s0, 4);

    // run C: restart from DONE, then reset mid-run
    do_start(1, 1);
    chk("c_count0", count, 0);
    chk("c_busy", busy, 1);
    chk("c_done0", done, 0);
    push(1, 1, 7, 0, 0);
    tick(2);
    chk("c_dist0", dist_entry, 0);
    chk("c_label", label_entry, 7);
    s0 = n_strobe;
    push(5, 5, 8, 32, 0);
    rst = 1'b0;
    e_drop = exp_q.pop_back();
    #1;
    chk("c_rst_busy", busy, 0);
    chk("c_rst_done", done, 0);
    chk("c_rst_en", en_list, 0);
    chk("c_rst_dist", dist_entry, 0);
    chk("c_rst_label", label_entry, 0);
    chk("c_rst_count", count, 0);
    chk("c_rst_ready", trn.in_ready, 0);
    tick(2);
    rst = 1'b1;
    tick(5);
    chk("c_no_strobe", n_strobe - s0, 0);
    chk("c_idle_busy", busy, 0);
    chk("c_idle_done", done, 0);
    chk("c_idle_dist", dist_entry, 0);

    // run D: extreme coordinates
    do_start(-32768, -32768);
    push(32767, 32767, 9, EXP_OVF, 0);
    tick();
    chk("d_en", en_list, 1);
    chk("d_dist", dist_entry, EXP_OVF);
    tick(3);
    chk("q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
